// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared definitions for the LC3 MAR/MDR memory-stage
//               sequencer. Holds the sequencer state codes and the
//               MDR-source select constants. The control FSM and the bench
//               import it as well as the sequencer RTL.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    localparam int c_STATE_W = 3;

    // State codes. Encoding 3'd7 is unused and recovers to IDLE.
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ADDR  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_READ  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_WRITE = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd6;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_ADDR  = c_ST_ADDR,
        ST_DATA  = c_ST_DATA,
        ST_WAIT  = c_ST_WAIT,
        ST_READ  = c_ST_READ,
        ST_WRITE = c_ST_WRITE,
        ST_DONE  = c_ST_DONE
    } lc3_mem_state_e;

    // MDR source select: memory output or the shared bus.
    localparam logic SEL_MDR_MEM = 1'b1;
    localparam logic SEL_MDR_BUS = 1'b0;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/lc3_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : lc3_wait_counter
// Description : Loadable down-counter used to time memory wait states.
//               Load takes priority over decrement; the counter saturates at
//               zero and flags it.
// Ports       : clk          - system clock
//               reset        - asynchronous active-low reset
//               i_load       - load i_load_value this cycle
//               i_load_value - value to load
//               i_dec        - decrement this cycle (ignored at zero)
//               o_zero       - counter value is zero
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : lc3_wait_counter
`default_nettype wire

// File: rtl/lc3_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_sequencer
// Description : Upstream controller for the LC3 MAR/MDR memory stage. Takes
//               one read/write request per transaction over valid/ready,
//               sequences ld_mar, ld_mdr, sel_mdr and mem_we with a fixed
//               number of wait states, tells the bus driver what to gate onto
//               Buss and pulses done. All outputs are decoded from registered
//               state only.
// Ports       : clk, reset (async active-low)
//               req_valid/req_write/req_ready - request handshake
//               gate_addr/gate_data           - bus driver selects
//               ld_mar/ld_mdr/sel_mdr/mem_we  - memory stage controls
//               busy/done                     - status
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_sequencer
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_write,
    output logic req_ready,
    output logic gate_addr,
    output logic gate_data,
    output logic ld_mar,
    output logic ld_mdr,
    output logic sel_mdr,
    output logic mem_we,
    output logic busy,
    output logic done
);

    localparam bit c_NO_WAIT = (WAIT_STATES == 0);
    // WAIT is entered with WAIT_STATES-1 loaded so that exactly WAIT_STATES
    // cycles are spent there (exit happens on the zero cycle).
    localparam logic [CNT_W-1:0] c_WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic                 r_write;
    logic                 r_out_of_reset;
    logic                 w_accept;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;

    // req_ready is itself a registered decode, so accepting adds no
    // combinational path from req_* to any output.
    assign w_accept   = req_valid && req_ready;
    assign w_cnt_load = (w_next_state == c_ST_WAIT) && (r_state != c_ST_WAIT);
    assign w_cnt_dec  = (r_state == c_ST_WAIT);

    lc3_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_cnt_load),
        .i_load_value (c_WAIT_LOAD),
        .i_dec        (w_cnt_dec),
        .o_zero       (w_cnt_zero)
    );

    // State register. r_out_of_reset holds req_ready low until the first
    // clock edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_write        <= 1'b0;
            r_out_of_reset <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_out_of_reset <= 1'b1;
            if (w_accept) begin
                r_write <= req_write;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: begin
                w_next_state = w_accept ? c_ST_ADDR : c_ST_IDLE;
            end
            c_ST_ADDR: begin
                if (r_write) begin
                    w_next_state = c_ST_DATA;
                end else begin
                    w_next_state = c_NO_WAIT ? c_ST_READ : c_ST_WAIT;
                end
            end
            c_ST_DATA: begin
                w_next_state = c_NO_WAIT ? c_ST_WRITE : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_next_state = r_write ? c_ST_WRITE : c_ST_READ;
                end else begin
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_READ:  w_next_state = c_ST_DONE;
            c_ST_WRITE: w_next_state = c_ST_DONE;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        req_ready = 1'b0;
        gate_addr = 1'b0;
        gate_data = 1'b0;
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        sel_mdr   = SEL_MDR_BUS;
        mem_we    = 1'b0;
        done      = 1'b0;
        busy      = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                req_ready = r_out_of_reset;
            end
            c_ST_ADDR: begin
                gate_addr = 1'b1;
                ld_mar    = 1'b1;
            end
            c_ST_DATA: begin
                gate_data = 1'b1;
                ld_mdr    = 1'b1;
                sel_mdr   = SEL_MDR_BUS;
            end
            c_ST_READ: begin
                ld_mdr  = 1'b1;
                sel_mdr = SEL_MDR_MEM;
            end
            c_ST_WRITE: begin
                mem_we = 1'b1;
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule : lc3_mem_sequencer
`default_nettype wire
